// File: rtl/frame_capture_if.sv
// Video-in / BRAM-out signal bundle for frame_capture.
// master = video source and BRAM side, slave = frame_capture.
interface frame_capture_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              capture_req;
    logic [23:0]       pixel_in;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              bram_we;
    logic              busy;
    logic              frame_valid;

    modport master (
        output capture_req, pixel_in, hcount, vcount,
        input  bram_addr, bram_din, bram_we, busy, frame_valid
    );

    modport slave (
        input  capture_req, pixel_in, hcount, vcount,
        output bram_addr, bram_din, bram_we, busy, frame_valid
    );
endinterface

// File: rtl/frame_capture.sv
// Single-frame RGB332 capture into a single-port BRAM; outside capture the same
// raster address counter drives playback reads.
module frame_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 400,
    parameter int unsigned ADDR_W   = 18
) (
    input  logic           clk,
    input  logic           rst,
    frame_capture_if.slave bus
);

    localparam int unsigned       FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [10:0]       H_LIM        = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM        = 10'(V_ACTIVE);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [7:0]        bram_din_q;
    logic              bram_we_q;

    logic              in_disp;
    logic              sof;
    logic [ADDR_W-1:0] used_addr;
    logic              write_en;
    logic              unused_pixel_bits;

    assign unused_pixel_bits = ^{bus.pixel_in[20:16], bus.pixel_in[12:8], bus.pixel_in[5:0]};

    always_comb begin
        in_disp   = (bus.hcount < H_LIM) && (bus.vcount < V_LIM);
        sof       = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
        used_addr = sof ? '0 : addr_cnt_q;
    end

    // Saturate at FRAME_PIXELS so a malformed timing source cannot walk past the frame.
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        if (sof) begin
            addr_cnt_d = ADDR_W'(1);
        end else if (in_disp && (32'(addr_cnt_q) < FRAME_PIXELS)) begin
            addr_cnt_d = addr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.capture_req) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (sof) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (in_disp && (used_addr == LAST_ADDR)) begin
                    state_d = StDone;
                end
            end
        endcase
    end

    // The ARMED->CAPTURE transition cycle already writes the sof pixel.
    assign write_en = in_disp && ((state_q == StCapture) || ((state_q == StArmed) && sof));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_cnt_q  <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            if (in_disp) begin
                bram_addr_q <= used_addr;
            end
            bram_din_q <= {bus.pixel_in[23:21], bus.pixel_in[15:13], bus.pixel_in[7:6]};
            bram_we_q  <= write_en;
        end
    end

    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_din    = bram_din_q;
    assign bus.bram_we     = bram_we_q;
    assign bus.busy        = (state_q == StArmed) || (state_q == StCapture);
    assign bus.frame_valid = (state_q == StDone);

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture on a reduced 20x10 raster (16x8 active) with a
// frame-level reference model and a behavioural BRAM.
module tb_frame_capture;

    localparam int HA    = 16;
    localparam int VA    = 8;
    localparam int HT    = 20;
    localparam int VT    = 10;
    localparam int AW    = 8;
    localparam int FRAME = HA * VA;
    localparam int LAST  = FRAME - 1;

    logic clk;
    logic rst;

    frame_capture_if #(.ADDR_W(AW)) bus ();

    frame_capture #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .ADDR_W  (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port BRAM (read-first) plus record of every write it sees.
    logic [7:0] bram_mem [256];
    logic [7:0] bram_dout;
    int         act_addr_q[$];
    logic [7:0] act_data_q[$];

    always @(posedge clk) begin
        if (bus.bram_we) begin
            bram_mem[bus.bram_addr] <= bus.bram_din;
            act_addr_q.push_back(int'(bus.bram_addr));
            act_data_q.push_back(bus.bram_din);
        end
        bram_dout <= bram_mem[bus.bram_addr];
    end

    // Reference model state: frame-level view of a capture request.
    bit         pending, capturing, m_valid;
    int         m_addr;
    int         exp_addr_q[$];
    logic [7:0] exp_data_q[$];
    logic [7:0] model_mem [256];

    int  pos_h, pos_v;
    bit  force_pix;
    int  checks, passed;

    function automatic logic [7:0] quant(input logic [23:0] p);
        return {p[23:21], p[15:13], p[7:6]};
    endfunction

    function automatic int stream_mismatch();
        if (act_addr_q.size() != exp_addr_q.size()) return -2;
        for (int i = 0; i < act_addr_q.size(); i++) begin
            if (act_addr_q[i] !== exp_addr_q[i] || act_data_q[i] !== exp_data_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic int raster_break();
        for (int i = 0; i < act_addr_q.size(); i++) begin
            if (act_addr_q[i] != i) return i;
        end
        return -1;
    endfunction

    task automatic clear_streams();
        act_addr_q.delete();
        act_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic set_pos(input int h, input int v);
        pos_h = h;
        pos_v = v;
        bus.hcount = 11'(h);
        bus.vcount = 10'(v);
    endtask

    // Model reacts to the inputs about to be sampled on the next edge.
    task automatic model_update();
        bit idle_before, ind, sof;
        logic [7:0] q;
        if (rst) begin
            pending   = 0;
            capturing = 0;
            m_valid   = 0;
            m_addr    = 0;
            return;
        end
        idle_before = !pending && !capturing;
        ind = (pos_h < HA) && (pos_v < VA);
        sof = (pos_h == 0) && (pos_v == 0);
        q   = quant(bus.pixel_in);
        if (ind) m_addr = pos_v * HA + pos_h;
        if (sof && pending) begin
            pending   = 0;
            capturing = 1;
        end
        if (capturing && ind) begin
            exp_addr_q.push_back(m_addr);
            exp_data_q.push_back(q);
            model_mem[m_addr] = q;
            if (m_addr == LAST) begin
                capturing = 0;
                m_valid   = 1;
            end
        end
        if (bus.capture_req && idle_before) begin
            pending = 1;
            m_valid = 0;
        end
    endtask

    task automatic step();
        int h, v;
        model_update();
        @(posedge clk);
        #1;
        bus.capture_req = 1'b0;
        h = pos_h + 1;
        v = pos_v;
        if (h >= HT) begin
            h = 0;
            v = (v + 1 >= VT) ? 0 : v + 1;
        end
        set_pos(h, v);
        bus.pixel_in = 24'($urandom);
        if (force_pix && h == 5 && v == 0) bus.pixel_in = 24'hE0E0C0;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(pos_h == h && pos_v == v) && n < 2 * HT * VT) begin
            step();
            n++;
        end
        if (!(pos_h == h && pos_v == v)) begin
            checks++;
            $display("FAIL run_to timeout: at (%0d,%0d) want (%0d,%0d)", pos_h, pos_v, h, v);
        end
    endtask

    task automatic pulse_req();
        bus.capture_req = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.capture_req = 1'($urandom);
            set_pos(int'($urandom_range(2047)), int'($urandom_range(1023)));
            step();
        end
        rst = 1'b0;
        checks++; if (bus.bram_addr !== 8'd0) $display("FAIL reset_addr: got %0h want 0", bus.bram_addr); else passed++;
        checks++; if (bus.bram_din !== 8'd0) $display("FAIL reset_din: got %0h want 0", bus.bram_din); else passed++;
        checks++; if (bus.bram_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", bus.bram_we); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passed++;
        checks++; if (bus.frame_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.frame_valid); else passed++;
        set_pos(HT - 2, VT - 1);
        clear_streams();
    endtask

    task automatic test_basic_capture();
        int r;
        force_pix = 1;
        run_to(5, 3);
        pulse_req();
        checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise: got %0b want 1", bus.busy); else passed++;
        run_to(0, 0);
        checks++; if (act_addr_q.size() !== 0) $display("FAIL basic_early_write: got %0d writes want 0", act_addr_q.size()); else passed++;
        checks++; if (bus.bram_we !== 1'b0) $display("FAIL basic_we_before_sof: got %0b want 0", bus.bram_we); else passed++;
        run_to(HA - 1, VA - 1);
        step();
        checks++; if (bus.bram_addr !== 8'(LAST)) $display("FAIL basic_last_addr: got %0d want %0d", bus.bram_addr, LAST); else passed++;
        checks++; if (bus.frame_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", bus.frame_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_fall: got %0b want 0", bus.busy); else passed++;
        step();
        checks++; if (act_addr_q.size() !== FRAME) $display("FAIL basic_count: got %0d want %0d", act_addr_q.size(), FRAME); else passed++;
        r = raster_break();
        checks++; if (r !== -1) $display("FAIL basic_raster: break at %0d want none", r); else passed++;
        r = stream_mismatch();
        checks++; if (r !== -1) $display("FAIL basic_stream: mismatch at %0d want none", r); else passed++;
        checks++; if (bram_mem[5] !== 8'hFF) $display("FAIL basic_quant: got %0h want ff", bram_mem[5]); else passed++;
        force_pix = 0;
    endtask

    task automatic test_playback();
        int rh, rv;
        clear_streams();
        run_to(5, 0);
        step();
        checks++; if (bus.bram_addr !== 8'd5) $display("FAIL play_addr: got %0d want 5", bus.bram_addr); else passed++;
        checks++; if (bus.bram_we !== 1'b0) $display("FAIL play_we: got %0b want 0", bus.bram_we); else passed++;
        step();
        checks++; if (bram_dout !== 8'hFF) $display("FAIL play_dout5: got %0h want ff", bram_dout); else passed++;
        rh = int'($urandom_range(HA - 1));
        rv = int'($urandom_range(VA - 1));
        run_to(rh, rv);
        step();
        step();
        checks++; if (bram_dout !== model_mem[rv * HA + rh]) $display("FAIL play_dout_rand: got %0h want %0h", bram_dout, model_mem[rv * HA + rh]); else passed++;
        checks++; if (act_addr_q.size() !== 0) $display("FAIL play_no_write: got %0d writes want 0", act_addr_q.size()); else passed++;
    endtask

    task automatic test_recapture();
        int r;
        clear_streams();
        run_to(2, 6);
        pulse_req();
        checks++; if (bus.frame_valid !== 1'b0) $display("FAIL recap_valid_drop: got %0b want 0", bus.frame_valid); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL recap_busy: got %0b want 1", bus.busy); else passed++;
        run_to(0, 0);
        run_to(HA - 1, VA - 1);
        step();
        checks++; if (bus.frame_valid !== 1'b1) $display("FAIL recap_valid: got %0b want 1", bus.frame_valid); else passed++;
        step();
        r = stream_mismatch();
        checks++; if (r !== -1 || act_addr_q.size() !== FRAME) $display("FAIL recap_stream: mismatch %0d count %0d want none/%0d", r, act_addr_q.size(), FRAME); else passed++;
    endtask

    task automatic test_ignored_request();
        int r;
        clear_streams();
        run_to(1, 9);
        pulse_req();
        pulse_req();
        run_to(0, 0);
        run_to(8, 4);
        pulse_req();
        checks++; if (bus.busy !== 1'b1) $display("FAIL ign_busy: got %0b want 1", bus.busy); else passed++;
        run_to(HA - 1, VA - 1);
        step();
        checks++; if (bus.frame_valid !== 1'b1) $display("FAIL ign_valid: got %0b want 1", bus.frame_valid); else passed++;
        step();
        checks++; if (act_addr_q.size() !== FRAME) $display("FAIL ign_count: got %0d want %0d", act_addr_q.size(), FRAME); else passed++;
        r = raster_break();
        checks++; if (r !== -1) $display("FAIL ign_raster: break at %0d want none", r); else passed++;
        clear_streams();
        run_to(0, 0);
        run_to(HA - 1, VA - 1);
        step();
        step();
        checks++; if (act_addr_q.size() !== 0) $display("FAIL ign_no_rearm: got %0d writes want 0", act_addr_q.size()); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL ign_idle_busy: got %0b want 0", bus.busy); else passed++;
    endtask

    task automatic test_short_frame();
        int r;
        clear_streams();
        run_to(3, 8);
        pulse_req();
        run_to(0, 0);
        run_to(3, 2);
        set_pos(0, 0);
        step();
        checks++; if (bus.bram_addr !== 8'd0 || bus.bram_we !== 1'b1) $display("FAIL short_restart: got addr %0d we %0b want 0/1", bus.bram_addr, bus.bram_we); else passed++;
        checks++; if (bus.frame_valid !== 1'b0) $display("FAIL short_valid_low: got %0b want 0", bus.frame_valid); else passed++;
        run_to(HA - 1, VA - 1);
        step();
        checks++; if (bus.frame_valid !== m_valid) $display("FAIL short_valid_end: got %0b want %0b", bus.frame_valid, m_valid); else passed++;
        step();
        r = stream_mismatch();
        checks++; if (r !== -1) $display("FAIL short_stream: mismatch at %0d want none (count %0d)", r, act_addr_q.size()); else passed++;
    endtask

    task automatic test_reset_mid_capture();
        int r;
        clear_streams();
        run_to(3, 8);
        pulse_req();
        run_to(0, 0);
        run_to(10, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.bram_we !== 1'b0) $display("FAIL rstmid_we: got %0b want 0", bus.bram_we); else passed++;
        checks++; if (bus.frame_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.frame_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", bus.busy); else passed++;
        clear_streams();
        run_to(0, 0);
        run_to(HA - 1, VA - 1);
        step();
        step();
        checks++; if (act_addr_q.size() !== 0) $display("FAIL rstmid_idle: got %0d writes want 0", act_addr_q.size()); else passed++;
        clear_streams();
        pulse_req();
        run_to(0, 0);
        run_to(HA - 1, VA - 1);
        step();
        step();
        checks++; if (act_addr_q.size() == 0 || act_addr_q[0] !== 0) $display("FAIL rstmid_first_addr: got count %0d want first addr 0", act_addr_q.size()); else passed++;
        r = stream_mismatch();
        checks++; if (r !== -1 || act_addr_q.size() !== FRAME) $display("FAIL rstmid_stream: mismatch %0d count %0d want none/%0d", r, act_addr_q.size(), FRAME); else passed++;
        checks++; if (bus.frame_valid !== 1'b1) $display("FAIL rstmid_valid_end: got %0b want 1", bus.frame_valid); else passed++;
    endtask

    initial begin
        checks          = 0;
        passed          = 0;
        force_pix       = 0;
        rst             = 1'b1;
        bus.capture_req = 1'b0;
        bus.pixel_in    = '0;
        set_pos(0, 0);
        test_reset();
        test_basic_capture();
        test_playback();
        test_recapture();
        test_ignored_request();
        test_short_frame();
        test_reset_mid_capture();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
